// File: rtl/frame_seq_pkg.sv
// Shared state encodings and sizing helpers for the frame sequencer.
// Optional vsync gating of the copy is enabled with FRAME_SEQ_VSYNC_EN.
package frame_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t COMPUTE   = 3'd1;
  localparam state_t WAIT_TICK = 3'd2;
  localparam state_t COPY      = 3'd3;
  localparam state_t DRAIN     = 3'd4;

  function automatic int cell_count(input int columns, input int rows);
    return columns * rows;
  endfunction

  function automatic int tick_width(input int frame_ticks);
    return $clog2(frame_ticks + 1);
  endfunction

endpackage

// File: rtl/frame_copy_pipe.sv
// Read-latency alignment pipe for the shadow-RAM to VRAM copy.
// Carries {valid, address} so each write lines up with its RAM read data.
module frame_copy_pipe #(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_address,
  output logic                  write_ena,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic                  empty
);

  logic [READ_LATENCY-1:0] valid_q;
  logic [ADDR_WIDTH-1:0]   address_q [READ_LATENCY];

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      valid_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        address_q[i] <= '0;
      end
    end else begin
      valid_q[0]   <= issue_valid;
      address_q[0] <= issue_address;
      for (int i = 1; i < READ_LATENCY; i++) begin
        valid_q[i]   <= valid_q[i-1];
        address_q[i] <= address_q[i-1];
      end
    end
  end

  assign write_ena     = valid_q[READ_LATENCY-1];
  assign write_address = address_q[READ_LATENCY-1];
  assign empty         = ~|valid_q;

endmodule

// File: rtl/frame_sequencer.sv
// Frame controller: starts the cell engine, holds the frame period, then copies shadow RAM into VRAM.
// Define FRAME_SEQ_VSYNC_EN to add vsync_i and hold the copy until a vsync pulse for tear-free output.
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int ACTIVE_COLUMNS    = 640,
  parameter int ACTIVE_ROWS       = 480,
  parameter int ADDR_WIDTH        = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
  parameter int DATA_WIDTH        = 1,
  parameter int FRAME_TICKS       = 100000000,
  parameter int READ_LATENCY      = 1,
  parameter int FRAME_COUNT_WIDTH = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic                         run_i,
  input  logic                         step_i,
`ifdef FRAME_SEQ_VSYNC_EN
  input  logic                         vsync_i,
`endif
  output logic                         engine_ready_o,
  input  logic                         engine_done_i,
  output logic [ADDR_WIDTH-1:0]        ram_read_address_o,
  input  logic [DATA_WIDTH-1:0]        ram_read_data_i,
  output logic [ADDR_WIDTH-1:0]        vram_write_address_o,
  output logic [DATA_WIDTH-1:0]        vram_write_data_o,
  output logic                         vram_write_ena_o,
  output logic                         busy_o,
  output logic                         frame_done_o,
  output logic                         overrun_o,
  output logic [FRAME_COUNT_WIDTH-1:0] frame_count_o
);

  localparam int CELLS      = cell_count(ACTIVE_COLUMNS, ACTIVE_ROWS);
  localparam int TICK_WIDTH = tick_width(FRAME_TICKS);
  localparam logic [TICK_WIDTH-1:0] TICK_MAX  = TICK_WIDTH'(FRAME_TICKS);
  localparam logic [TICK_WIDTH-1:0] TICK_LAST = TICK_WIDTH'(FRAME_TICKS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CELLS - 1);

  state_t                       state_q;
  logic [TICK_WIDTH-1:0]        tick_q;
  logic [ADDR_WIDTH-1:0]        read_address_q;
  logic                         engine_ready_q;
  logic                         overrun_q;
  logic [FRAME_COUNT_WIDTH-1:0] frame_count_q;

  logic                  pipe_write_ena;
  logic [ADDR_WIDTH-1:0] pipe_write_address;
  logic                  pipe_empty;
  logic                  tick_reached;
  logic                  copy_go;
  logic                  frame_end;
  logic                  start_frame;

  assign tick_reached = (tick_q >= TICK_LAST);

`ifdef FRAME_SEQ_VSYNC_EN
  // Only vsync pulses seen once the frame period has elapsed may release the copy.
  logic vsync_seen_q;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      vsync_seen_q <= 1'b0;
    end else if (state_q == COMPUTE || state_q == WAIT_TICK) begin
      if (tick_reached && vsync_i) begin
        vsync_seen_q <= 1'b1;
      end
    end else begin
      vsync_seen_q <= 1'b0;
    end
  end

  assign copy_go = tick_reached && (vsync_i || vsync_seen_q);
`else
  assign copy_go = tick_reached;
`endif

  assign frame_end   = (state_q == DRAIN) && pipe_empty;
  assign start_frame = ((state_q == IDLE) && (run_i || step_i)) || (frame_end && run_i);

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q        <= IDLE;
      tick_q         <= '0;
      read_address_q <= '0;
      engine_ready_q <= 1'b0;
      overrun_q      <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      engine_ready_q <= start_frame;

      if (start_frame) begin
        tick_q <= '0;
      end else if ((state_q == COMPUTE || state_q == WAIT_TICK) && tick_q != TICK_MAX) begin
        tick_q <= tick_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (start_frame) begin
            state_q <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (engine_done_i) begin
            if (tick_q > TICK_LAST) begin
              overrun_q <= 1'b1;
            end
            if (copy_go) begin
              state_q        <= COPY;
              read_address_q <= '0;
            end else begin
              state_q <= WAIT_TICK;
            end
          end
        end
        WAIT_TICK: begin
          if (copy_go) begin
            state_q        <= COPY;
            read_address_q <= '0;
          end
        end
        COPY: begin
          // The address parks on the last cell so it never reaches CELLS.
          if (read_address_q == LAST_ADDR) begin
            state_q <= DRAIN;
          end else begin
            read_address_q <= read_address_q + 1'b1;
          end
        end
        DRAIN: begin
          if (frame_end) begin
            frame_count_q <= frame_count_q + 1'b1;
            state_q       <= run_i ? COMPUTE : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  frame_copy_pipe #(
    .READ_LATENCY(READ_LATENCY),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_copy_pipe (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .issue_valid  (state_q == COPY),
    .issue_address(read_address_q),
    .write_ena    (pipe_write_ena),
    .write_address(pipe_write_address),
    .empty        (pipe_empty)
  );

  assign engine_ready_o       = engine_ready_q;
  assign ram_read_address_o   = read_address_q;
  assign vram_write_ena_o     = pipe_write_ena;
  assign vram_write_address_o = pipe_write_address;
  assign vram_write_data_o    = pipe_write_ena ? ram_read_data_i : '0;
  assign busy_o               = (state_q != IDLE);
  assign frame_done_o         = frame_end;
  assign overrun_o            = overrun_q;
  assign frame_count_o        = frame_count_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer on a 4x3 grid, FRAME_TICKS=20, 4-bit cells, RAM data = addr^4'hA.
// Extra instances with READ_LATENCY 1 and 4 and a 2-bit frame counter cover latency and wrap.
`timescale 1ns/1ps
module tb_frame_sequencer;

  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int N    = 12;
  localparam int F    = 20;
  localparam int DW   = 4;
  localparam int AW   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic reset_n = 1'b0;
  logic run     = 1'b0;
  logic step    = 1'b0;

  // Main instance, READ_LATENCY=2
  logic          done_m = 1'b0;
  logic          ready_m, wr_ena_m, busy_m, fdone_m, overrun_m;
  logic [AW-1:0] rd_addr_m, wr_addr_m;
  logic [DW-1:0] rd_data_m, wr_data_m;
  logic [15:0]   count_m;
  logic [DW-1:0] ram_m [2] = '{4'd0, 4'd0};

  // Sweep instances: a = READ_LATENCY 1, b = READ_LATENCY 4
  logic          run_a = 1'b0, run_b = 1'b0;
  logic          done_a = 1'b0, done_b = 1'b0;
  logic          ready_a, wr_ena_a, busy_a, fdone_a, overrun_a;
  logic          ready_b, wr_ena_b, busy_b, fdone_b, overrun_b;
  logic [AW-1:0] rd_addr_a, wr_addr_a, rd_addr_b, wr_addr_b;
  logic [DW-1:0] rd_data_a, wr_data_a, rd_data_b, wr_data_b;
  logic [1:0]    count_a, count_b;
  logic [DW-1:0] ram_a = 4'd0;
  logic [DW-1:0] ram_b [4] = '{4'd0, 4'd0, 4'd0, 4'd0};

  frame_sequencer #(
    .ACTIVE_COLUMNS(COLS), .ACTIVE_ROWS(ROWS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .FRAME_TICKS(F), .READ_LATENCY(2), .FRAME_COUNT_WIDTH(16)
  ) dut (
    .clk_i(clk), .reset_ni(reset_n), .run_i(run), .step_i(step),
`ifdef FRAME_SEQ_VSYNC_EN
    .vsync_i(1'b1),
`endif
    .engine_ready_o(ready_m), .engine_done_i(done_m),
    .ram_read_address_o(rd_addr_m), .ram_read_data_i(rd_data_m),
    .vram_write_address_o(wr_addr_m), .vram_write_data_o(wr_data_m), .vram_write_ena_o(wr_ena_m),
    .busy_o(busy_m), .frame_done_o(fdone_m), .overrun_o(overrun_m), .frame_count_o(count_m)
  );

  frame_sequencer #(
    .ACTIVE_COLUMNS(COLS), .ACTIVE_ROWS(ROWS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .FRAME_TICKS(F), .READ_LATENCY(1), .FRAME_COUNT_WIDTH(2)
  ) dut_a (
    .clk_i(clk), .reset_ni(reset_n), .run_i(run_a), .step_i(1'b0),
`ifdef FRAME_SEQ_VSYNC_EN
    .vsync_i(1'b1),
`endif
    .engine_ready_o(ready_a), .engine_done_i(done_a),
    .ram_read_address_o(rd_addr_a), .ram_read_data_i(rd_data_a),
    .vram_write_address_o(wr_addr_a), .vram_write_data_o(wr_data_a), .vram_write_ena_o(wr_ena_a),
    .busy_o(busy_a), .frame_done_o(fdone_a), .overrun_o(overrun_a), .frame_count_o(count_a)
  );

  frame_sequencer #(
    .ACTIVE_COLUMNS(COLS), .ACTIVE_ROWS(ROWS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .FRAME_TICKS(F), .READ_LATENCY(4), .FRAME_COUNT_WIDTH(2)
  ) dut_b (
    .clk_i(clk), .reset_ni(reset_n), .run_i(run_b), .step_i(1'b0),
`ifdef FRAME_SEQ_VSYNC_EN
    .vsync_i(1'b1),
`endif
    .engine_ready_o(ready_b), .engine_done_i(done_b),
    .ram_read_address_o(rd_addr_b), .ram_read_data_i(rd_data_b),
    .vram_write_address_o(wr_addr_b), .vram_write_data_o(wr_data_b), .vram_write_ena_o(wr_ena_b),
    .busy_o(busy_b), .frame_done_o(fdone_b), .overrun_o(overrun_b), .frame_count_o(count_b)
  );

  // Shadow RAM models: data is addr^A, delayed by each instance's read latency.
  always @(posedge clk) begin
    ram_m[0] <= rd_addr_m ^ 4'hA;
    ram_m[1] <= ram_m[0];
    ram_a    <= rd_addr_a ^ 4'hA;
    ram_b[0] <= rd_addr_b ^ 4'hA;
    for (int i = 1; i < 4; i++) ram_b[i] <= ram_b[i-1];
  end
  assign rd_data_m = ram_m[1];
  assign rd_data_a = ram_a;
  assign rd_data_b = ram_b[3];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Engine models: done pulse a fixed number of cycles after each ready pulse.
  int done_delay_m = 5;
  int eng_cnt_m = 0, eng_cnt_a = 0, eng_cnt_b = 0;
  always @(negedge clk) begin
    done_m = 1'b0;
    if (eng_cnt_m > 0) begin eng_cnt_m--; if (eng_cnt_m == 0) done_m = 1'b1; end
    if (ready_m) eng_cnt_m = done_delay_m;
    done_a = 1'b0;
    if (eng_cnt_a > 0) begin eng_cnt_a--; if (eng_cnt_a == 0) done_a = 1'b1; end
    if (ready_a) eng_cnt_a = 5;
    done_b = 1'b0;
    if (eng_cnt_b > 0) begin eng_cnt_b--; if (eng_cnt_b == 0) done_b = 1'b1; end
    if (ready_b) eng_cnt_b = 5;
  end

  // Write monitors: sequential addresses 0..N-1, data addr^A, latency from ready to first write.
  int wr_count_m = 0, exp_addr_m = 0, ready_cyc_m = 0, first_wr_cyc_m = 0, ready_pulses_m = 0;
  int wr_count_a = 0, exp_addr_a = 0, ready_cyc_a = 0, lat_a = 0, frames_a = 0;
  int wr_count_b = 0, exp_addr_b = 0, ready_cyc_b = 0, lat_b = 0, frames_b = 0;

  always @(negedge clk) begin
    if (ready_m) begin ready_cyc_m = cyc; ready_pulses_m++; end
    if (wr_ena_m) begin
      if (wr_count_m == 0) first_wr_cyc_m = cyc;
      checkOutput("main_wr_addr", 32'(wr_addr_m), 32'(exp_addr_m));
      checkOutput("main_wr_data", 32'(wr_data_m), 32'((exp_addr_m ^ 10) & 15));
      wr_count_m++;
      exp_addr_m = (exp_addr_m == N - 1) ? 0 : exp_addr_m + 1;
    end

    if (ready_a) ready_cyc_a = cyc;
    if (wr_ena_a) begin
      if (wr_count_a == 0) lat_a = cyc - ready_cyc_a;
      checkOutput("l1_wr_addr", 32'(wr_addr_a), 32'(exp_addr_a));
      checkOutput("l1_wr_data", 32'(wr_data_a), 32'((exp_addr_a ^ 10) & 15));
      wr_count_a++;
      exp_addr_a = (exp_addr_a == N - 1) ? 0 : exp_addr_a + 1;
    end
    if (fdone_a) begin
      checkOutput("l1_count_wrap", 32'(count_a), 32'(frames_a % 4));
      frames_a++;
    end

    if (ready_b) ready_cyc_b = cyc;
    if (wr_ena_b) begin
      if (wr_count_b == 0) lat_b = cyc - ready_cyc_b;
      checkOutput("l4_wr_addr", 32'(wr_addr_b), 32'(exp_addr_b));
      checkOutput("l4_wr_data", 32'(wr_data_b), 32'((exp_addr_b ^ 10) & 15));
      wr_count_b++;
      exp_addr_b = (exp_addr_b == N - 1) ? 0 : exp_addr_b + 1;
    end
    if (fdone_b) begin
      checkOutput("l4_count_wrap", 32'(count_b), 32'(frames_b % 4));
      frames_b++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst_n, input logic run_v, input logic step_v);
    reset_n = rst_n;
    run     = run_v;
    step    = step_v;
    tick();
  endtask

  task automatic waitFrameMain(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!fdone_m && n < 300);
    checkOutput(tag, 32'(fdone_m), 32'd1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ready"},   32'(ready_m),   32'd0);
    checkOutput({tag, "_wr_ena"},  32'(wr_ena_m),  32'd0);
    checkOutput({tag, "_wr_addr"}, 32'(wr_addr_m), 32'd0);
    checkOutput({tag, "_wr_data"}, 32'(wr_data_m), 32'd0);
    checkOutput({tag, "_rd_addr"}, 32'(rd_addr_m), 32'd0);
    checkOutput({tag, "_busy"},    32'(busy_m),    32'd0);
    checkOutput({tag, "_fdone"},   32'(fdone_m),   32'd0);
    checkOutput({tag, "_overrun"}, 32'(overrun_m), 32'd0);
    checkOutput({tag, "_count"},   32'(count_m),   32'd0);
  endtask

  initial begin
    int p;
    int n;

    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkAllZero("reset");

    // Free-running frame with early engine done
    wr_count_m   = 0;
    done_delay_m = 5;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t1_ready", 32'(ready_m), 32'd1);
    checkOutput("t1_busy",  32'(busy_m),  32'd1);
    waitFrameMain("t1_frame_done");
    checkOutput("t1_writes",  32'(wr_count_m), 32'd12);
    checkOutput("t1_latency", 32'(first_wr_cyc_m - ready_cyc_m), 32'(F + 2));
    checkOutput("t1_overrun", 32'(overrun_m), 32'd0);
    tick();
    checkOutput("t1_count",     32'(count_m), 32'd1);
    checkOutput("t1_next_ready", 32'(ready_m), 32'd1);

    // Late engine done: overrun and copy right after done
    done_delay_m = 30;
    wr_count_m   = 0;
    waitFrameMain("t2_frame_done");
    checkOutput("t2_overrun", 32'(overrun_m), 32'd1);
    checkOutput("t2_latency", 32'(first_wr_cyc_m - ready_cyc_m), 32'd33);
    checkOutput("t2_writes",  32'(wr_count_m), 32'd12);
    tick();
    checkOutput("t2_count", 32'(count_m), 32'd2);
    checkOutput("t2_ready", 32'(ready_m), 32'd1);

    // run dropped during COMPUTE: frame completes, then IDLE
    done_delay_m = 5;
    wr_count_m   = 0;
    tick(); tick(); tick();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t4_busy_mid", 32'(busy_m), 32'd1);
    waitFrameMain("t4_frame_done");
    checkOutput("t4_writes", 32'(wr_count_m), 32'd12);
    tick();
    checkOutput("t4_count", 32'(count_m), 32'd3);
    checkOutput("t4_busy",  32'(busy_m),  32'd0);
    checkOutput("t4_ready", 32'(ready_m), 32'd0);
    p = ready_pulses_m;
    repeat (10) tick();
    checkOutput("t4_no_restart", 32'(ready_pulses_m), 32'(p));

    // Single step while paused; step during COPY is ignored
    wr_count_m = 0;
    p = ready_pulses_m;
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    n = 0;
    while (wr_count_m == 0 && n < 100) begin tick(); n++; end
    checkOutput("t3_copy_reached", 32'(wr_count_m > 0), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitFrameMain("t3_frame_done");
    tick();
    checkOutput("t3_count", 32'(count_m), 32'd4);
    checkOutput("t3_busy",  32'(busy_m),  32'd0);
    repeat (20) tick();
    checkOutput("t3_one_frame",   32'(ready_pulses_m), 32'(p + 1));
    checkOutput("t3_writes",      32'(wr_count_m),     32'd12);
    checkOutput("t3_idle",        32'(busy_m),         32'd0);
    checkOutput("t3_overrun_sticky", 32'(overrun_m),   32'd1);

    // Reset after the 5th write of COPY
    wr_count_m = 0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    n = 0;
    while (!(wr_ena_m && wr_addr_m == 4'd4) && n < 100) begin tick(); n++; end
    checkOutput("t5_fifth_write", 32'(wr_ena_m && wr_addr_m == 4'd4), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkAllZero("t5_reset");
    checkOutput("t5_writes_before", 32'(wr_count_m), 32'd5);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t5_no_more_writes", 32'(wr_count_m), 32'd5);
    wr_count_m = 0;
    exp_addr_m = 0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitFrameMain("t5_frame_done");
    checkOutput("t5_writes", 32'(wr_count_m), 32'd12);
    tick();
    checkOutput("t5_count", 32'(count_m), 32'd1);
    checkOutput("t5_busy",  32'(busy_m),  32'd0);

    // Latency sweep and 2-bit frame counter wrap over 5 frames
    run_a = 1'b1;
    run_b = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (fdone_a && frames_a == 4) run_a = 1'b0;
      if (fdone_b && frames_b == 4) run_b = 1'b0;
    end while (!(frames_a >= 5 && frames_b >= 5 && !busy_a && !busy_b) && n < 1000);
    checkOutput("l1_frames",  32'(frames_a),   32'd5);
    checkOutput("l4_frames",  32'(frames_b),   32'd5);
    checkOutput("l1_writes",  32'(wr_count_a), 32'd60);
    checkOutput("l4_writes",  32'(wr_count_b), 32'd60);
    checkOutput("l1_count",   32'(count_a),    32'd1);
    checkOutput("l4_count",   32'(count_b),    32'd1);
    checkOutput("l1_latency", 32'(lat_a),      32'(F + 1));
    checkOutput("l4_latency", 32'(lat_b),      32'(F + 4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
